depp_reg_bridge: RTL and testbench
==================================

DEPP_REG_BRIDGE -- requirements
Module: depp_reg_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning stream FIFO entries (power of 2, 4..16).
REQ-002 SHALL have parameter ID_VALUE, default 8'hD5, meaning value returned at address 0x0F.
REQ-003 i_clk_8mhz  in  1  sole clock; all logic on its rising edge.
REQ-004 i_rst_n  in  1  reset; asynchronous, active-low.
REQ-005 i_req_valid  in  1  one-cycle request pulse from the DEPP front end.
REQ-006 i_req_write  in  1  1 = write request, 0 = read request; qualified by i_req_valid.
REQ-007 i_req_addr  in  8  register address.
REQ-008 i_req_wdata  in  8  write data.
REQ-009 o_rsp_valid  out  1  one-cycle completion pulse, for both reads and writes.
REQ-010 o_rsp_rdata  out  8  read data, valid while o_rsp_valid=1; 0x00 for writes.
REQ-011 o_busy  out  1  high while a request is in flight.
REQ-012 o_led  out  4  LED register bits [3:0].
REQ-013 o_fifo_empty / o_fifo_full  out  1 each  FIFO status.

Function
REQ-014 Request accepted only when i_req_valid=1 and o_busy=0; o_busy asserts the next cycle.
REQ-015 Accepted in cycle N: o_rsp_valid=1 and o_busy=1 in cycle N+1; o_busy=0 in N+2; peak rate is one request per 2 cycles.
REQ-016 i_req_valid while o_busy=1 SHALL be ignored (no side effects except REQ-026).
REQ-017 Address map: 0x00-0x03 SCRATCH0-3 RW; 0x04 LED RW (bits[7:4] read 0); 0x08 FIFO data; 0x09 STATUS RO; 0x0A CTRL WO; 0x0B DROPCNT RO; 0x0F ID RO.
REQ-018 Unmapped reads SHALL return 0x00; unmapped and RO-address writes SHALL be ignored; CTRL reads 0x00.
REQ-019 Write to 0x08 pushes i_req_wdata; push when full discards data, sets sticky OVF, count unchanged.
REQ-020 Read of 0x08 pops head to o_rsp_rdata; pop when empty returns 0x00, sets sticky UNF, pointers unchanged.
REQ-021 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH (5 bits).
REQ-022 STATUS = {OVF, UNF, full, empty, count[3:0]}; count=16 reads count[3:0]=0 with full=1.
REQ-023 CTRL write: bit0=1 flushes FIFO (pointers and count to 0, data not cleared); bit1=1 clears OVF and UNF; both may be set together.
REQ-024 o_fifo_empty/o_fifo_full SHALL reflect count combinationally from registered state, updated the cycle after a push/pop/flush is accepted.
REQ-025 o_led SHALL equal LED[3:0] register at all times.

Configuration
REQ-026 With macro DEPP_BRIDGE_DROPCNT_EN defined, DROPCNT SHALL count requests ignored under REQ-016, saturating at 0xFF, cleared by CTRL bit1; without it, DROPCNT reads 0x00 and no counter logic exists.

Reset
REQ-027 While i_rst_n=0: o_rsp_valid=0, o_rsp_rdata=0x00, o_busy=0, o_led=0x0, o_fifo_empty=1, o_fifo_full=0.
REQ-028 Reset SHALL clear SCRATCH0-3, LED, FIFO pointers/count, OVF, UNF, DROPCNT; FIFO storage contents need not reset.
REQ-029 Reset asserted mid-request SHALL cancel it: no o_rsp_valid after release, no register side effect.
REQ-030 First request accepted in the first rising edge with i_rst_n=1 and i_req_valid=1.

Verification
REQ-031 Write 0x5A to 0x02, read 0x02 -> read o_rsp_rdata=0x5A one cycle after acceptance; o_busy high exactly 1 cycle per request.
REQ-032 Write 0x0C to 0x04 -> o_led=4'hC; read 0x04 -> 0x0C; read 0x0F -> 0xD5; read 0x30 -> 0x00.
REQ-033 Push 0x01..0x10 (16) -> STATUS=0x20, o_fifo_full=1; 17th push 0x99 -> STATUS=0xA0; 16 pops return 0x01..0x10 in order; 17th pop -> 0x00, STATUS=0xD0.
REQ-034 Push 3, write CTRL=0x03 -> STATUS=0x10, flags clear; push 0xAB, pop -> 0xAB (pointer wrap after 20 total pushes verified).
REQ-035 With DEPP_BRIDGE_DROPCNT_EN: pulse i_req_valid on two consecutive cycles -> second ignored, DROPCNT=0x01; 300 drops -> 0xFF; without macro DROPCNT=0x00.
REQ-036 Assert i_rst_n=0 in the cycle after accepting write 0x77 to 0x00 -> no o_rsp_valid, SCRATCH0 reads 0x00 after release.

Source files
------------

// File: rtl/depp_reg_bridge.sv
// depp_reg_bridge: byte-wide register bridge behind a DEPP front end.
// Scratch registers, an LED register, a byte stream FIFO with sticky
// overflow/underflow flags, a status register and an ID register. Each
// accepted request completes with a one-cycle response pulse on the next cycle.
// Optional feature: define DEPP_BRIDGE_DROPCNT_EN to build the saturating
// counter of requests that arrive while busy (readable at 0x0B).
module depp_reg_bridge #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  ID_VALUE   = 8'hD5
) (
    input  logic       i_clk_8mhz,
    input  logic       i_rst_n,
    input  logic       i_req_valid,
    input  logic       i_req_write,
    input  logic [7:0] i_req_addr,
    input  logic [7:0] i_req_wdata,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_rdata,
    output logic       o_busy,
    output logic [3:0] o_led,
    output logic       o_fifo_empty,
    output logic       o_fifo_full
);

    localparam int unsigned PW         = $clog2(FIFO_DEPTH);
    localparam logic [4:0]  DEPTH_CNT  = 5'(FIFO_DEPTH);

    localparam logic [7:0]  A_LED      = 8'h04;
    localparam logic [7:0]  A_FIFO     = 8'h08;
    localparam logic [7:0]  A_STATUS   = 8'h09;
    localparam logic [7:0]  A_CTRL     = 8'h0A;
    localparam logic [7:0]  A_DROPCNT  = 8'h0B;
    localparam logic [7:0]  A_ID       = 8'h0F;

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            accept;
    logic            wr_acc;
    logic            rd_acc;
    logic            push;
    logic            pop;
    logic            ctrl_wr;

    logic [7:0]      scratch [4];
    logic [3:0]      led;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [4:0]      count;
    logic            ovf;
    logic            unf;
    logic [7:0]      dropcnt;
    logic [7:0]      status;
    logic [7:0]      rd_mux;
    logic [7:0]      rsp_rdata;

    assign accept  = i_req_valid && (state == S_IDLE);
    assign wr_acc  = accept && i_req_write;
    assign rd_acc  = accept && !i_req_write;
    assign push    = wr_acc && (i_req_addr == A_FIFO);
    assign pop     = rd_acc && (i_req_addr == A_FIFO);
    assign ctrl_wr = wr_acc && (i_req_addr == A_CTRL);

    assign o_fifo_empty = (count == '0);
    assign o_fifo_full  = (count == DEPTH_CNT);
    assign o_led        = led;
    assign o_rsp_rdata  = rsp_rdata;
    assign status       = {ovf, unf, o_fifo_full, o_fifo_empty, count[3:0]};

    // State register: idle, or presenting the response of the last accepted request.
    always_ff @(posedge i_clk_8mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs: every accepted request takes exactly one response cycle.
    always_comb begin
        state_nxt   = state;
        o_busy      = 1'b0;
        o_rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_req_valid) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                o_busy      = 1'b1;
                o_rsp_valid = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read data selection from pre-request register state.
    always_comb begin
        rd_mux = '0;
        case (i_req_addr)
            8'h00, 8'h01, 8'h02, 8'h03: rd_mux = scratch[i_req_addr[1:0]];
            A_LED:                      rd_mux = {4'h0, led};
            A_FIFO:                     rd_mux = o_fifo_empty ? '0 : mem[rptr];
            A_STATUS:                   rd_mux = status;
            A_DROPCNT:                  rd_mux = dropcnt;
            A_ID:                       rd_mux = ID_VALUE;
            default:                    rd_mux = '0;
        endcase
    end

    // Response data register: read data for accepted reads, zero otherwise.
    always_ff @(posedge i_clk_8mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_rdata <= '0;
        end else if (rd_acc) begin
            rsp_rdata <= rd_mux;
        end else begin
            rsp_rdata <= '0;
        end
    end

    // Scratch and LED registers, written by accepted writes to their addresses.
    always_ff @(posedge i_clk_8mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                scratch[i] <= '0;
            end
            led <= '0;
        end else if (wr_acc) begin
            if (i_req_addr[7:2] == 6'd0) begin
                scratch[i_req_addr[1:0]] <= i_req_wdata;
            end else if (i_req_addr == A_LED) begin
                led <= i_req_wdata[3:0];
            end
        end
    end

    // FIFO storage: not reset, written only on a push that has room.
    always_ff @(posedge i_clk_8mhz) begin
        if (push && !o_fifo_full) begin
            mem[wptr] <= i_req_wdata;
        end
    end

    // FIFO pointers, occupancy and sticky error flags, plus CTRL flush/clear.
    always_ff @(posedge i_clk_8mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (push) begin
                if (o_fifo_full) begin
                    ovf <= 1'b1;
                end else begin
                    wptr  <= wptr + PW'(1);
                    count <= count + 5'd1;
                end
            end
            if (pop) begin
                if (o_fifo_empty) begin
                    unf <= 1'b1;
                end else begin
                    rptr  <= rptr + PW'(1);
                    count <= count - 5'd1;
                end
            end
            if (ctrl_wr) begin
                if (i_req_wdata[0]) begin
                    wptr  <= '0;
                    rptr  <= '0;
                    count <= '0;
                end
                if (i_req_wdata[1]) begin
                    ovf <= 1'b0;
                    unf <= 1'b0;
                end
            end
        end
    end

`ifdef DEPP_BRIDGE_DROPCNT_EN
    // Saturating count of requests presented while a response is in flight.
    always_ff @(posedge i_clk_8mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dropcnt <= '0;
        end else if (ctrl_wr && i_req_wdata[1]) begin
            dropcnt <= '0;
        end else if (i_req_valid && (state == S_RESP) && (dropcnt != 8'hFF)) begin
            dropcnt <= dropcnt + 8'd1;
        end
    end
`else
    assign dropcnt = '0;
`endif

endmodule

// File: tb/tb_depp_reg_bridge.sv
// Testbench for depp_reg_bridge: directed scenarios followed by randomized
// register traffic, all compared against a queue/array reference model.
`timescale 1ns/1ps
module tb_depp_reg_bridge;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic [3:0] led;
    logic       fifo_empty;
    logic       fifo_full;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_scratch [4];
    logic [3:0] m_led;
    logic [7:0] m_fifo [$];
    logic       m_ovf;
    logic       m_unf;
    int         m_drop;

    depp_reg_bridge #(
        .FIFO_DEPTH (16),
        .ID_VALUE   (8'hD5)
    ) dut (
        .i_clk_8mhz   (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .i_req_write  (req_write),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .o_busy       (busy),
        .o_led        (led),
        .o_fifo_empty (fifo_empty),
        .o_fifo_full  (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_scratch[i] = 8'h00;
        m_led = 4'h0;
        m_fifo.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_drop = 0;
    endtask

    function automatic logic [7:0] model_status();
        int sz;
        sz = m_fifo.size();
        return {m_ovf, m_unf, sz == DEPTH, sz == 0, 4'(sz % 16)};
    endfunction

    function automatic logic [7:0] model_dropcnt();
`ifdef DEPP_BRIDGE_DROPCNT_EN
        return 8'((m_drop > 255) ? 255 : m_drop);
`else
        return 8'h00;
`endif
    endfunction

    // Applies one accepted request to the model and returns the expected response data.
    task automatic model_access(input logic w, input logic [7:0] a, input logic [7:0] d,
                                output logic [7:0] exp);
        exp = 8'h00;
        if (w) begin
            if (a < 8'd4) m_scratch[a[1:0]] = d;
            else if (a == 8'h04) m_led = d[3:0];
            else if (a == 8'h08) begin
                if (m_fifo.size() == DEPTH) m_ovf = 1'b1;
                else m_fifo.push_back(d);
            end else if (a == 8'h0A) begin
                if (d[0]) m_fifo.delete();
                if (d[1]) begin
                    m_ovf = 1'b0;
                    m_unf = 1'b0;
                    m_drop = 0;
                end
            end
        end else begin
            if (a < 8'd4) exp = m_scratch[a[1:0]];
            else if (a == 8'h04) exp = {4'h0, m_led};
            else if (a == 8'h08) begin
                if (m_fifo.size() == 0) m_unf = 1'b1;
                else exp = m_fifo.pop_front();
            end
            else if (a == 8'h09) exp = model_status();
            else if (a == 8'h0B) exp = model_dropcnt();
            else if (a == 8'h0F) exp = 8'hD5;
        end
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_busy"},  {7'd0, busy}, 8'h00);
        check({tag, "_rspv"},  {7'd0, rsp_valid}, 8'h00);
        check({tag, "_led"},   {4'd0, led}, {4'd0, m_led});
        check({tag, "_empty"}, {7'd0, fifo_empty}, {7'd0, m_fifo.size() == 0});
        check({tag, "_full"},  {7'd0, fifo_full}, {7'd0, m_fifo.size() == DEPTH});
    endtask

    // One request from an idle bridge: drive, check response cycle, check return to idle.
    task automatic req(input string tag, input logic w, input logic [7:0] a,
                       input logic [7:0] d, output logic [7:0] rd);
        logic [7:0] exp;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model_access(w, a, d, exp);
        check({tag, "_rspv"}, {7'd0, rsp_valid}, 8'h01);
        check({tag, "_busy1"}, {7'd0, busy}, 8'h01);
        rd = rsp_rdata;
        check({tag, "_rdata"}, rd, exp);
        @(posedge clk);
        #1;
        check_idle_state(tag);
    endtask

    logic [7:0] rd;
    logic [7:0] pool [14];
    int         pulses;

    initial begin
        pool = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h08, 8'h08, 8'h08,
                 8'h09, 8'h09, 8'h0A, 8'h0B, 8'h0F, 8'h00};
        model_reset();
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h0F;
        req_wdata = 8'h00;

        // Reset values, with a request already pending
        repeat (3) @(posedge clk);
        #1;
        check("rst_rspv",  {7'd0, rsp_valid}, 8'h00);
        check("rst_rdata", rsp_rdata, 8'h00);
        check("rst_busy",  {7'd0, busy}, 8'h00);
        check("rst_led",   {4'd0, led}, 8'h00);
        check("rst_empty", {7'd0, fifo_empty}, 8'h01);
        check("rst_full",  {7'd0, fifo_full}, 8'h00);

        // First edge after release accepts the pending ID read
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("first_rspv",  {7'd0, rsp_valid}, 8'h01);
        check("first_rdata", rsp_rdata, 8'hD5);
        @(posedge clk);
        #1;
        check_idle_state("first");

        // Scratch and LED basics
        req("wr_s2", 1'b1, 8'h02, 8'h5A, rd);
        req("rd_s2", 1'b0, 8'h02, 8'h00, rd);
        check("s2_const", rd, 8'h5A);
        req("wr_led", 1'b1, 8'h04, 8'h0C, rd);
        check("led_const", {4'd0, led}, 8'h0C);
        req("rd_led", 1'b0, 8'h04, 8'h00, rd);
        req("rd_id", 1'b0, 8'h0F, 8'h00, rd);
        req("rd_unmapped", 1'b0, 8'h30, 8'h00, rd);
        req("wr_id", 1'b1, 8'h0F, 8'h11, rd);
        req("rd_ctrl", 1'b0, 8'h0A, 8'h00, rd);

        // Fill, overflow, drain, underflow
        for (int i = 1; i <= 16; i++) req("push", 1'b1, 8'h08, 8'(i), rd);
        req("st_full", 1'b0, 8'h09, 8'h00, rd);
        check("st_full_const", rd, 8'h20);
        req("push_ovf", 1'b1, 8'h08, 8'h99, rd);
        req("st_ovf", 1'b0, 8'h09, 8'h00, rd);
        check("st_ovf_const", rd, 8'hA0);
        for (int i = 1; i <= 16; i++) req("pop", 1'b0, 8'h08, 8'h00, rd);
        req("pop_unf", 1'b0, 8'h08, 8'h00, rd);
        req("st_unf", 1'b0, 8'h09, 8'h00, rd);
        check("st_unf_const", rd, 8'hD0);

        // Flush and flag clear, then a wrapped pointer push/pop
        for (int i = 0; i < 3; i++) req("push3", 1'b1, 8'h08, 8'(8'h40 + i), rd);
        req("ctrl3", 1'b1, 8'h0A, 8'h03, rd);
        req("st_flush", 1'b0, 8'h09, 8'h00, rd);
        check("st_flush_const", rd, 8'h10);
        req("push_ab", 1'b1, 8'h08, 8'hAB, rd);
        req("pop_ab", 1'b0, 8'h08, 8'h00, rd);
        check("pop_ab_const", rd, 8'hAB);

        // Back-to-back pulse: second one is dropped without side effects
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h0B;
        @(posedge clk);
        #1;
        model_access(1'b0, 8'h0B, 8'h00, rd);
        check("b2b_rdata", rsp_rdata, rd);
        req_write = 1'b1;
        req_addr  = 8'h01;
        req_wdata = 8'hEE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        m_drop++;
        check_idle_state("b2b");
        req("b2b_s1", 1'b0, 8'h01, 8'h00, rd);
        req("b2b_drop", 1'b0, 8'h0B, 8'h00, rd);

        // Held request line: one accept every other cycle, drop counter saturates
        pulses = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h30;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) pulses++;
        end
        req_valid = 1'b0;
        m_drop += 350;
        check("held_pulses", 8'(pulses / 2), 8'(175));
        req("sat_drop", 1'b0, 8'h0B, 8'h00, rd);
        req("clr_drop", 1'b1, 8'h0A, 8'h02, rd);
        req("drop_zero", 1'b0, 8'h0B, 8'h00, rd);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [7:0] a;
            logic       w;
            a = pool[$urandom_range(0, 13)];
            if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(0, 255));
            w = 1'($urandom_range(0, 1));
            if (a == 8'h0A && $urandom_range(0, 3) != 0) w = 1'b0;
            req("rand", w, a, 8'($urandom_range(0, 255)), rd);
        end

        // Reset during the response cycle of a write cancels it
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h00;
        req_wdata = 8'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("mid_acc_rspv", {7'd0, rsp_valid}, 8'h01);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_rspv",  {7'd0, rsp_valid}, 8'h00);
        check("mid_rst_rdata", rsp_rdata, 8'h00);
        check_idle_state("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_rspv", {7'd0, rsp_valid}, 8'h00);
        req("mid_s0", 1'b0, 8'h00, 8'h00, rd);
        req("mid_status", 1'b0, 8'h09, 8'h00, rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
